// File: rtl/spi_master_fifo.sv
// MMIO SPI master (mode 0, MSB first) with a TX FIFO of {ignore, byte} entries
// and an RX FIFO of captured response bytes, read back through the data register.
module spi_master_fifo #(
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned RX_DEPTH = 8,
  parameter int unsigned CLK_DIV  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_wr,
  input  logic       spi_rd,
  input  logic       spi_addr_sel,
  input  logic [7:0] spi_din,
  input  logic       spi_ignore_response,
  output logic [7:0] spi_dout,
  output logic       spi_buffer_full,
  output logic       spi_buffer_empty,
  output logic       spi_data_avail,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned TX_AW  = $clog2(TX_DEPTH);
  localparam int unsigned RX_AW  = $clog2(RX_DEPTH);
  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_DONE,
    S_HOLD
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic               rise_half;
  logic [BYTE_W-1:0]  tx_sh;
  logic [BYTE_W-1:0]  rx_sh;
  logic               ign_q;
  logic [1:0]         miso_sync;
  logic               miso_s;
  logic               div_end;

  // TX FIFO: pointers carry an extra wrap bit to tell full from empty
  logic [BYTE_W:0]    tx_mem [TX_DEPTH];
  logic [TX_AW:0]     tx_wr_ptr;
  logic [TX_AW:0]     tx_rd_ptr;
  logic               tx_empty;
  logic               tx_full;
  logic               tx_push;
  logic               tx_pop;
  logic [BYTE_W:0]    tx_head;

  logic [BYTE_W-1:0]  rx_mem [RX_DEPTH];
  logic [RX_AW:0]     rx_wr_ptr;
  logic [RX_AW:0]     rx_rd_ptr;
  logic               rx_empty;
  logic               rx_full;
  logic               rx_push;
  logic               rx_pop;

  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full  = (tx_wr_ptr[TX_AW] != tx_rd_ptr[TX_AW]) &&
                    (tx_wr_ptr[TX_AW-1:0] == tx_rd_ptr[TX_AW-1:0]);
  assign tx_push  = spi_wr && !tx_full;
  assign tx_pop   = !tx_empty && ((state == S_IDLE) || (state == S_DONE));
  assign tx_head  = tx_mem[tx_rd_ptr[TX_AW-1:0]];

  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full  = (rx_wr_ptr[RX_AW] != rx_rd_ptr[RX_AW]) &&
                    (rx_wr_ptr[RX_AW-1:0] == rx_rd_ptr[RX_AW-1:0]);
  assign rx_push  = (state == S_DONE) && !ign_q && !rx_full;
  assign rx_pop   = spi_rd && !spi_addr_sel && !rx_empty;

  // Flags and read data come straight from FIFO state so the same-cycle latch sees pre-pop values
  assign spi_dout         = rx_empty ? '0 : rx_mem[rx_rd_ptr[RX_AW-1:0]];
  assign spi_buffer_full  = tx_full;
  assign spi_buffer_empty = tx_empty && (state == S_IDLE);
  assign spi_data_avail   = !rx_empty;

  assign miso_s  = miso_sync[1];
  assign div_end = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr[TX_AW-1:0]] <= {spi_ignore_response, spi_din};
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wr_ptr[RX_AW-1:0]] <= rx_sh;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      miso_sync <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + (TX_AW+1)'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + (TX_AW+1)'(1);
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + (RX_AW+1)'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + (RX_AW+1)'(1);
      miso_sync <= {miso_sync[0], miso};
    end
  end

  // Shift engine: each SHIFT bit is a rising half (sample) followed by a falling half (next MOSI bit)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      rise_half <= 1'b0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      ign_q     <= 1'b0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      cs_n      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          div_cnt <= '0;
          if (!tx_empty) begin
            tx_sh <= tx_head[BYTE_W-1:0];
            ign_q <= tx_head[BYTE_W];
            mosi  <= tx_head[BYTE_W-1];
            cs_n  <= 1'b0;
            state <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (div_end) begin
            div_cnt   <= '0;
            sclk      <= 1'b1;
            rise_half <= 1'b1;
            bit_cnt   <= BIT_W'(BYTE_W - 1);
            rx_sh     <= {rx_sh[BYTE_W-2:0], miso_s};
            state     <= S_SHIFT;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        S_SHIFT: begin
          if (div_end) begin
            div_cnt <= '0;
            if (rise_half) begin
              sclk      <= 1'b0;
              rise_half <= 1'b0;
              if (bit_cnt != '0) begin
                mosi  <= tx_sh[BYTE_W-2];
                tx_sh <= {tx_sh[BYTE_W-2:0], 1'b0};
              end
            end else if (bit_cnt != '0) begin
              bit_cnt   <= bit_cnt - BIT_W'(1);
              sclk      <= 1'b1;
              rise_half <= 1'b1;
              rx_sh     <= {rx_sh[BYTE_W-2:0], miso_s};
            end else begin
              state <= S_DONE;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        S_DONE: begin
          div_cnt <= '0;
          if (!tx_empty) begin
            tx_sh <= tx_head[BYTE_W-1:0];
            ign_q <= tx_head[BYTE_W];
            mosi  <= tx_head[BYTE_W-1];
            state <= S_SETUP;
          end else begin
            state <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (div_end) begin
            div_cnt <= '0;
            cs_n    <= 1'b1;
            state   <= S_IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_fifo.sv
// Self-checking bench for spi_master_fifo: vector table, directed corner cases,
// and randomized loopback bursts checked against a queue-based reference model.
module tb_spi_master_fifo;

  localparam int unsigned TX_DEPTH = 8;
  localparam int unsigned RX_DEPTH = 8;
  localparam int unsigned CLK_DIV  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_wr = 1'b0;
  logic       spi_rd = 1'b0;
  logic       spi_addr_sel = 1'b0;
  logic [7:0] spi_din = 8'h00;
  logic       spi_ignore_response = 1'b0;
  logic [7:0] spi_dout;
  logic       spi_buffer_full;
  logic       spi_buffer_empty;
  logic       spi_data_avail;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       cs_n;

  spi_master_fifo #(
    .TX_DEPTH(TX_DEPTH),
    .RX_DEPTH(RX_DEPTH),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .spi_wr             (spi_wr),
    .spi_rd             (spi_rd),
    .spi_addr_sel       (spi_addr_sel),
    .spi_din            (spi_din),
    .spi_ignore_response(spi_ignore_response),
    .spi_dout           (spi_dout),
    .spi_buffer_full    (spi_buffer_full),
    .spi_buffer_empty   (spi_buffer_empty),
    .spi_data_avail     (spi_data_avail),
    .sclk               (sclk),
    .mosi               (mosi),
    .miso               (miso),
    .cs_n               (cs_n)
  );

  assign miso = mosi;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cs_low = 0;
  int cs_rises = 0;
  logic mosi_bits[$];

  always @(posedge sclk) mosi_bits.push_back(mosi);
  always @(negedge clk) if (rst_n && !cs_n) cs_low++;
  always @(posedge cs_n) cs_rises++;

  typedef struct {
    logic [7:0] data;
    logic       ign;
    logic       exp_avail;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] bits_byte(input int j);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (8 * j + k < mosi_bits.size()) b = {b[6:0], mosi_bits[8 * j + k]};
    end
    return b;
  endfunction

  task automatic write1(input logic [7:0] d, input logic ign);
    @(negedge clk);
    spi_wr = 1'b1;
    spi_din = d;
    spi_ignore_response = ign;
    @(negedge clk);
    spi_wr = 1'b0;
  endtask

  task automatic write_bytes(input logic [7:0] d[$], input logic ign[$]);
    for (int i = 0; i < d.size(); i++) begin
      @(negedge clk);
      spi_wr = 1'b1;
      spi_din = d[i];
      spi_ignore_response = ign[i];
    end
    @(negedge clk);
    spi_wr = 1'b0;
  endtask

  task automatic read_byte(input logic sel, output logic [7:0] v);
    @(negedge clk);
    v = spi_dout;
    spi_rd = 1'b1;
    spi_addr_sel = sel;
    @(negedge clk);
    spi_rd = 1'b0;
    spi_addr_sel = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!spi_buffer_empty && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, 32'(spi_buffer_empty), 32'd1);
  endtask

  task automatic wait_not_full();
    int n;
    n = 0;
    while (spi_buffer_full && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("tx_not_full", 32'(spi_buffer_full), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    logic [7:0] rx_model[$];
    logic [7:0] tx_d[$];
    logic       tx_i[$];
    int lat;
    int n;
    int k;

    vecs[0] = '{data: 8'hA5, ign: 1'b0, exp_avail: 1'b1, exp_dout: 8'hA5};
    vecs[1] = '{data: 8'h3C, ign: 1'b1, exp_avail: 1'b0, exp_dout: 8'h00};
    vecs[2] = '{data: 8'h00, ign: 1'b0, exp_avail: 1'b1, exp_dout: 8'h00};
    vecs[3] = '{data: 8'hFF, ign: 1'b0, exp_avail: 1'b1, exp_dout: 8'hFF};
    vecs[4] = '{data: 8'h81, ign: 1'b1, exp_avail: 1'b0, exp_dout: 8'h00};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_empty", 32'(spi_buffer_empty), 32'd1);
    chk("rst_full", 32'(spi_buffer_full), 32'd0);
    chk("rst_avail", 32'(spi_data_avail), 32'd0);
    chk("rst_dout", 32'(spi_dout), 32'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cs_n", 32'(cs_n), 32'd1);
    chk("post_rst_empty", 32'(spi_buffer_empty), 32'd1);

    // Single-byte vector table
    for (int t = 0; t < 5; t++) begin
      mosi_bits.delete();
      cs_low = 0;
      cs_rises = 0;
      write1(vecs[t].data, vecs[t].ign);
      lat = 0;
      while (!sclk && lat < 100) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk("first_rise_latency", 32'(lat), 32'(CLK_DIV + 1));
      wait_idle("vec");
      chk("vec_sclk_pulses", 32'(mosi_bits.size()), 32'd8);
      chk("vec_mosi_byte", 32'(bits_byte(0)), 32'(vecs[t].data));
      chk("vec_cs_low_cycles", 32'(cs_low), 32'(18 * CLK_DIV + 1));
      chk("vec_cs_rises", 32'(cs_rises), 32'd1);
      chk("vec_mosi_idle_hold", 32'(mosi), 32'(vecs[t].data[0]));
      chk("vec_avail", 32'(spi_data_avail), 32'(vecs[t].exp_avail));
      chk("vec_dout", 32'(spi_dout), 32'(vecs[t].exp_dout));
      read_byte(1'b1, v);
      chk("status_read_avail", 32'(spi_data_avail), 32'(vecs[t].exp_avail));
      read_byte(1'b0, v);
      chk("pop_value", 32'(v), 32'(vecs[t].exp_dout));
      chk("avail_after_pop", 32'(spi_data_avail), 32'd0);
      chk("dout_after_pop", 32'(spi_dout), 32'h00);
    end

    // Burst while busy: the ninth write lands on a full FIFO and is dropped
    mosi_bits.delete();
    cs_rises = 0;
    write1(8'hEE, 1'b1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("burst_full", 32'(spi_buffer_full), 32'(i == 8));
      spi_wr = 1'b1;
      spi_din = 8'(i + 1);
      spi_ignore_response = 1'b0;
    end
    @(negedge clk);
    spi_wr = 1'b0;
    wait_idle("burst");
    chk("burst_sclk_pulses", 32'(mosi_bits.size()), 32'd72);
    chk("burst_cs_rises", 32'(cs_rises), 32'd1);
    chk("burst_mosi_first", 32'(bits_byte(0)), 32'hEE);
    for (int i = 1; i <= 8; i++) chk("burst_mosi", 32'(bits_byte(i)), 32'(i));
    for (int i = 1; i <= 8; i++) begin
      read_byte(1'b0, v);
      chk("burst_rx", 32'(v), 32'(i));
    end
    chk("burst_rx_drained", 32'(spi_data_avail), 32'd0);

    // RX overflow: ten responses, only the first eight are kept
    for (int i = 0; i < 10; i++) begin
      wait_not_full();
      write1(8'h10 + 8'(i), 1'b0);
    end
    wait_idle("ovf");
    chk("ovf_avail", 32'(spi_data_avail), 32'd1);
    chk("ovf_dout", 32'(spi_dout), 32'h10);
    for (int i = 0; i < 8; i++) begin
      read_byte(1'b0, v);
      chk("ovf_rx", 32'(v), 32'h10 + 32'(i));
    end
    chk("ovf_drained", 32'(spi_data_avail), 32'd0);

    // Randomized loopback bursts against a queue model of both FIFOs
    rx_model.delete();
    for (int r = 0; r < 15; r++) begin
      tx_d.delete();
      tx_i.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        tx_d.push_back(8'($urandom));
        tx_i.push_back(1'($urandom_range(0, 1)));
        if (!tx_i[i] && rx_model.size() < RX_DEPTH) rx_model.push_back(tx_d[i]);
      end
      mosi_bits.delete();
      write_bytes(tx_d, tx_i);
      wait_idle("rand");
      chk("rand_sclk_pulses", 32'(mosi_bits.size()), 32'(8 * n));
      for (int i = 0; i < n; i++) chk("rand_mosi", 32'(bits_byte(i)), 32'(tx_d[i]));
      chk("rand_avail", 32'(spi_data_avail), 32'(rx_model.size() != 0));
      chk("rand_dout", 32'(spi_dout), (rx_model.size() != 0) ? 32'(rx_model[0]) : 32'h00);
      k = $urandom_range(0, rx_model.size());
      for (int i = 0; i < k; i++) begin
        read_byte(1'b0, v);
        chk("rand_rx", 32'(v), 32'(rx_model.pop_front()));
      end
    end
    while (rx_model.size() != 0) begin
      read_byte(1'b0, v);
      chk("rand_rx_drain", 32'(v), 32'(rx_model.pop_front()));
    end
    chk("rand_drained", 32'(spi_data_avail), 32'd0);

    // Reset mid-byte aborts at once; the next write transfers normally
    mosi_bits.delete();
    write1(8'h77, 1'b0);
    n = 0;
    while (mosi_bits.size() < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("midbyte_rises", 32'(mosi_bits.size() >= 3), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n", 32'(cs_n), 32'd1);
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_empty", 32'(spi_buffer_empty), 32'd1);
    chk("abort_avail", 32'(spi_data_avail), 32'd0);
    chk("abort_dout", 32'(spi_dout), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    mosi_bits.delete();
    write1(8'h55, 1'b0);
    wait_idle("after_abort");
    chk("after_abort_pulses", 32'(mosi_bits.size()), 32'd8);
    chk("after_abort_mosi", 32'(bits_byte(0)), 32'h55);
    chk("after_abort_avail", 32'(spi_data_avail), 32'd1);
    chk("after_abort_dout", 32'(spi_dout), 32'h55);
    read_byte(1'b0, v);
    chk("after_abort_pop", 32'(v), 32'h55);
    chk("after_abort_drained", 32'(spi_data_avail), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
